// File: rtl/approx_rc_adder_pipe.sv
// approx_rc_adder_pipe: streaming ripple-carry adder whose low APPROX bit
// positions can use an approximate cell (S = A, Cout = B). The carry chain is
// cut into CHUNK-bit segments with one register stage per segment, giving a
// latency of WIDTH/CHUNK cycles under a global valid/ready stall.
// Optional feature macro: APPROX_RC_ERR_STAT_EN builds an exact-sum shadow
// pipeline and saturating error statistics (err_cnt, err_abs_sum).
module approx_rc_adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int APPROX = 4,
  parameter int CHUNK  = 4,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  IN1,
  input  logic [WIDTH-1:0]  IN2,
  input  logic              approx_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH:0]    Out,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] err_cnt,
  output logic [STAT_W-1:0] err_abs_sum
);

  localparam int L = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_chk_chunk
    $error("approx_rc_adder_pipe: WIDTH must be a multiple of CHUNK");
  end
  if (APPROX > WIDTH) begin : g_chk_approx
    $error("approx_rc_adder_pipe: APPROX must not exceed WIDTH");
  end

  // One CHUNK-wide ripple segment; base is the absolute position of bit 0.
  function automatic logic [CHUNK:0] add_seg(input logic [CHUNK-1:0] a,
                                             input logic [CHUNK-1:0] b,
                                             input logic cin,
                                             input logic ae,
                                             input int base);
    logic             c;
    logic [CHUNK-1:0] s;
    c = cin;
    s = '0;
    for (int j = 0; j < CHUNK; j++) begin
      if (ae && ((base + j) < APPROX)) begin
        s[j] = a[j];
        c    = b[j];
      end else begin
        s[j] = a[j] ^ b[j] ^ c;
        c    = (a[j] & b[j]) | (a[j] & c) | (b[j] & c);
      end
    end
    return {c, s};
  endfunction

  // Global stall: every stage moves together when the output slot is free.
  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < L; k++) begin : g_stage
    // Operand bits still to be added; the current segment sits at the LSBs.
    localparam int RW = WIDTH - k * CHUNK;

    logic [RW-1:0]    a_d, b_d;
    logic [WIDTH-1:0] s_d, s_next;
    logic             c_d, ae_d, vld_d;
    logic [CHUNK:0]   seg;
    logic [WIDTH-1:0] s_p;
    logic             c_p;
    logic             vld_p;

    if (k == 0) begin : g_src
      assign a_d   = IN1;
      assign b_d   = IN2;
      assign s_d   = '0;
      assign c_d   = 1'b0;
      assign ae_d  = approx_en;
      assign vld_d = in_valid;
    end else begin : g_src
      assign a_d   = g_stage[k-1].g_ops.a_p;
      assign b_d   = g_stage[k-1].g_ops.b_p;
      assign s_d   = g_stage[k-1].s_p;
      assign c_d   = g_stage[k-1].c_p;
      assign ae_d  = g_stage[k-1].g_ops.ae_p;
      assign vld_d = g_stage[k-1].vld_p;
    end

    assign seg = add_seg(a_d[CHUNK-1:0], b_d[CHUNK-1:0], c_d, ae_d, k * CHUNK);

    // Merge this segment's sum bits into the sum bits carried with the beat.
    always_comb begin
      s_next = s_d;
      s_next[k*CHUNK +: CHUNK] = seg[CHUNK-1:0];
    end

    // ---- stage k boundary: valid, partial sum, segment carry-out ----
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        if (k == L - 1) begin
          s_p <= '0;
          c_p <= 1'b0;
        end
      end else if (adv) begin
        vld_p <= vld_d;
        s_p   <= s_next;
        c_p   <= seg[CHUNK];
      end
    end

    if (k < L - 1) begin : g_ops
      logic [RW-CHUNK-1:0] a_p, b_p;
      logic                ae_p;
      // Skew registers: upper operand bits and the mode flag ride with the beat.
      always_ff @(posedge clk) begin
        if (adv) begin
          a_p  <= a_d[RW-1:CHUNK];
          b_p  <= b_d[RW-1:CHUNK];
          ae_p <= ae_d;
        end
      end
    end

`ifdef APPROX_RC_ERR_STAT_EN
    logic [WIDTH:0] ex_d, ex_p;
    if (k == 0) begin : g_ex
      assign ex_d = {1'b0, IN1} + {1'b0, IN2};
    end else begin : g_ex
      assign ex_d = g_stage[k-1].ex_p;
    end
    // Exact reference sum travels in lockstep with the approximate result.
    always_ff @(posedge clk) begin
      if (adv) ex_p <= ex_d;
    end
`endif
  end

  assign Out       = {g_stage[L-1].c_p, g_stage[L-1].s_p};
  assign out_valid = g_stage[L-1].vld_p;

`ifdef APPROX_RC_ERR_STAT_EN
  localparam int AW = STAT_W + WIDTH + 2;

  // Clamp a widened accumulator back into STAT_W bits.
  function automatic logic [STAT_W-1:0] sat_acc(input logic [AW-1:0] x);
    if (x > AW'({STAT_W{1'b1}})) return '1;
    return x[STAT_W-1:0];
  endfunction

  logic [WIDTH:0] ex_out, diff;
  logic [AW-1:0]  acc_wide;
  logic           consume;

  assign ex_out   = g_stage[L-1].ex_p;
  assign diff     = (Out > ex_out) ? (Out - ex_out) : (ex_out - Out);
  assign acc_wide = AW'(err_abs_sum) + AW'(diff);
  assign consume  = out_valid && out_ready;

  // Error statistics: updated on consume, saturating, clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      err_cnt     <= '0;
      err_abs_sum <= '0;
    end else if (consume && (diff != '0)) begin
      if (err_cnt != '1) err_cnt <= err_cnt + STAT_W'(1);
      err_abs_sum <= sat_acc(acc_wide);
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign err_cnt         = '0;
  assign err_abs_sum     = '0;
`endif

endmodule

// File: doc/approx_rc_adder_pipe.md
# approx_rc_adder_pipe

Parametrised, pipelined ripple-carry adder whose low `APPROX` bit positions use the area-optimised approximate cell and whose remaining positions use exact full adders. The carry chain is cut into `CHUNK`-bit segments with a register between them, and the block carries a valid/ready stream interface. A per-transaction `approx_en` flag selects approximate or exact arithmetic at run time. It is the streaming successor of the fixed 8-bit combinational approximate ripple-carry adders and sits in datapaths that trade accuracy for area and power.

## Interface
Parameters:
- `WIDTH`, 8: operand width; must be a multiple of `CHUNK`.
- `APPROX`, 4: number of approximate LSB positions, 0..`WIDTH`.
- `CHUNK`, 4: bits per pipeline segment; latency L = `WIDTH`/`CHUNK`.
- `STAT_W`, 32: width of the error-statistics counters.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: operand beat valid.
- `in_ready`, out, 1: block accepts a beat this cycle.
- `IN1`, in, `WIDTH`: operand A.
- `IN2`, in, `WIDTH`: operand B.
- `approx_en`, in, 1: 1 = approximate LSBs, 0 = fully exact; sampled with the beat.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `Out`, out, `WIDTH`+1: sum including carry-out.
- `stat_clr`, in, 1: synchronous clear of the statistics.
- `err_cnt`, out, `STAT_W`: number of results that differ from the exact sum.
- `err_abs_sum`, out, `STAT_W`: accumulated |approx − exact|.

## Operation
- Approximate cell at bit i (i < `APPROX`, `approx_en`=1): S = A[i] and Cout = B[i]. The carry-in is ignored.
- Exact cell: S = A^B^Cin and Cout = majority(A,B,Cin).
- Carry-in to bit 0 is 0. If `APPROX`=0 or `approx_en`=0, the result equals the exact `IN1`+`IN2`.
- Segment k covers bits [k·CHUNK +: CHUNK].
  - Stage k registers segment k's sum bits, its carry-out, and the not-yet-added upper operand bits.
  - Already-computed lower sum bits and the `approx_en` flag travel with the beat (skew/deskew registers).
- `Out` = {final carry, all sum bits}, presented together after L stages.
- Pipeline control is a global stall, with a valid bit per stage:
  - Every stage advances when `out_ready` or `!out_valid`.
  - Otherwise every stage holds.
  - `in_ready` has the same condition.
  - Bubbles are not squeezed out.
- A beat is accepted when `in_valid && in_ready`.
- A result is consumed when `out_valid && out_ready`.
- Arithmetic is unsigned; no overflow other than the carry into `Out[WIDTH]`.
- `WIDTH`/`CHUNK` is enforced by an elaboration-time check; `APPROX` > `WIDTH` is an elaboration error.

## Timing
- Latency: a beat accepted at cycle t gives `out_valid`=1 from cycle t+L.
- Throughput: 1 beat per cycle with `out_ready` held high.
- `in_ready` is combinational from `out_ready` and the last stage's valid.
- `Out`, `out_valid` and all stage valids are registered.
- Stall: while `out_valid && !out_ready`, `Out` is held stable and no beat is accepted.
- Reset (`rst_n`=0 at a rising edge):
  - All stage valids, `out_valid`, `Out`, `err_cnt` and `err_abs_sum` go to 0.
  - In-flight beats are discarded, including mid-stall.
  - `in_ready` reads 1 in the first cycle after reset.
- Statistics:
  - They update on the cycle a result is consumed, using an exact sum carried alongside the pipeline.
  - Both counters saturate at all-ones.
  - `stat_clr` clears both counters. If a consume happens in the same cycle, the clear wins and that result is not counted.

## Configuration
- `APPROX_RC_ERR_STAT_EN`:
  - Defined: the parallel exact-sum pipeline and both statistics counters are built.
  - Undefined: no exact-sum logic is built. `err_cnt` and `err_abs_sum` are tied to 0, `stat_clr` is ignored, and the ports remain so the interface is unchanged.

## Test plan
All scenarios use defaults (`WIDTH`=8, `APPROX`=4, `CHUNK`=4, L=2) with the macro defined.
1. `IN1`=0x0F, `IN2`=0x01, `approx_en`=1 -> `Out`=0x00F at t+2; `err_cnt`=1 and `err_abs_sum`=1 after consume.
2. `IN1`=0x35, `IN2`=0x4A: `approx_en`=1 -> `Out`=0x085; `approx_en`=0 -> `Out`=0x07F. Statistics increase by 1 / 6 only for the approximate beat.
3. `IN1`=0xFF, `IN2`=0xFF: `approx_en`=1 -> 0x1FF; `approx_en`=0 -> 0x1FE. Checks the carry into `Out[8]`.
4. Back-to-back stream of 16 beats with `out_ready` toggled 1,0,0,1,... -> results in order, none lost or duplicated, `Out` stable while stalled, `in_ready` low exactly when stalled.
5. `rst_n` asserted while 2 beats are in flight and the output is stalled -> `out_valid`=0 and `Out`=0 the next cycle, and neither beat ever appears.
6. `stat_clr` in the same cycle as an erroneous consume -> both counters 0. Separately, preload 2^`STAT_W`−1 (`STAT_W`=4 build) -> counters hold at 0xF.
